serial_subtractor: RTL and testbench

- Bit-serial subtractor: the inverse arithmetic path to the team's ripple-carry adder.
- Computes diff = a0 - a1 - bi over N bits, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Used where area matters more than latency.
- Operands are captured on a start/busy/done handshake, so it can sit behind a register-mapped ALU front end.

---
 rtl/sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 29 ++
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor slice.
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   cnt_width : width of the bit counter for an N-bit operand, never below 1
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold values 0..N, so $clog2(N+1); clamp to 1 bit for tiny N.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives, purely combinational.
//   d  : difference bit  x ^ y ^ bi
//   bo : borrow out      (~x & y) | (~(x ^ y) & bi)
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
module full_subtractor (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  logic xy;
  logic nx;
  logic nxy;
  logic t_lo;
  logic t_eq;

  xor g_xy  (xy, x, y);
  xor g_d   (d, xy, bi);
  not g_nx  (nx, x);
  and g_lo  (t_lo, nx, y);
  not g_nxy (nxy, xy);
  and g_eq  (t_eq, nxy, bi);
  or  g_bo  (bo, t_lo, t_eq);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a0 - a1 - bi (mod 2^N), one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, accepted whenever not busy (IDLE or DONE)
//   a0    : minuend, captured on accepted start
//   a1    : subtrahend, captured on accepted start
//   bi    : borrow-in, captured on accepted start
//   busy  : high while bits are being processed (RUN)
//   done  : one-cycle pulse when diff/bo become valid (DONE)
//   diff  : result, held until the next completion
//   bo    : final borrow-out, held with diff
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bo
);

  localparam int unsigned CW = cnt_width(N);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   a0_sr;
  logic [N-1:0]   a1_sr;
  logic [N-1:0]   res_sr;
  logic [N-1:0]   res_nxt;
  logic           borrow;
  logic           d_bit;
  logic           b_nxt;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last;

  full_subtractor u_fs (
    .d  (d_bit),
    .bo (b_nxt),
    .x  (a0_sr[0]),
    .y  (a1_sr[0]),
    .bi (borrow)
  );

  always_comb begin
    accept  = start && (state != ST_RUN);
    last    = (cnt == CW'(N - 1));
    // New bit enters at the MSB; after N shifts bit 0 of the result sits at the LSB.
    res_nxt = N'({d_bit, res_sr} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are only sampled on an accepted start, so X on the inputs at
  // any other time never reaches the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_sr  <= '0;
      a1_sr  <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bo     <= 1'b0;
    end else if (accept) begin
      a0_sr  <= a0;
      a1_sr  <= a1;
      borrow <= bi;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      a0_sr  <= a0_sr >> 1;
      a1_sr  <= a1_sr >> 1;
      res_sr <= res_nxt;
      borrow <= b_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= res_nxt;
        bo   <= b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor at N = 4, 1 and 8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s4_start, s4_bi, s4_busy, s4_done, s4_bo;
  logic [3:0] s4_a0, s4_a1, s4_diff;
  logic       s1_start, s1_bi, s1_busy, s1_done, s1_bo;
  logic [0:0] s1_a0, s1_a1, s1_diff;
  logic       s8_start, s8_bi, s8_busy, s8_done, s8_bo;
  logic [7:0] s8_a0, s8_a1, s8_diff;

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .a0(s4_a0), .a1(s4_a1), .bi(s4_bi),
    .busy(s4_busy), .done(s4_done), .diff(s4_diff), .bo(s4_bo));
  serial_subtractor #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .a0(s1_a0), .a1(s1_a1), .bi(s1_bi),
    .busy(s1_busy), .done(s1_done), .diff(s1_diff), .bo(s1_bo));
  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .a0(s8_a0), .a1(s8_a1), .bi(s8_bi),
    .busy(s8_busy), .done(s8_done), .diff(s8_diff), .bo(s8_bo));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Each op task is entered at a negedge; lat counts cycles from the
  // accepting edge until done is seen (bounded).
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic b,
                     output int lat, output int busyc);
    s4_start = 1'b1; s4_a0 = x; s4_a1 = y; s4_bi = b;
    lat = 0; busyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) s4_start = 1'b0;
      if (s4_busy) busyc++;
    end while (!s4_done && lat < 30);
  endtask

  task automatic op1(input logic x, input logic y, input logic b, output int lat);
    s1_start = 1'b1; s1_a0 = x; s1_a1 = y; s1_bi = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) s1_start = 1'b0;
    end while (!s1_done && lat < 30);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic b, output int lat);
    s8_start = 1'b1; s8_a0 = x; s8_a1 = y; s8_bi = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) s8_start = 1'b0;
    end while (!s8_done && lat < 40);
  endtask

  typedef struct {
    logic [3:0] a0;
    logic [3:0] a1;
    logic       bi;
    logic [3:0] exp_d;
    logic       exp_bo;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int lat, busyc, pulses;
    int t, expd;
    logic [7:0] x8, y8;
    logic x1, y1, b;

    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1};
    vecs[5] = '{4'h8, 4'h1, 1'b1, 4'h6, 1'b0};
    vecs[6] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};

    s4_start = 0; s4_a0 = 0; s4_a1 = 0; s4_bi = 0;
    s1_start = 0; s1_a0 = 0; s1_a1 = 0; s1_bi = 0;
    s8_start = 0; s8_a0 = 0; s8_a1 = 0; s8_bi = 0;

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(s4_busy), 0);
    chk("reset done", 32'(s4_done), 0);
    chk("reset diff", 32'(s4_diff), 0);
    chk("reset bo", 32'(s4_bo), 0);
    chk("reset busy n8", 32'(s8_busy), 0);
    chk("reset diff n8", 32'(s8_diff), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      op4(vecs[i].a0, vecs[i].a1, vecs[i].bi, lat, busyc);
      chk($sformatf("vec%0d diff", i), 32'(s4_diff), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d bo", i), 32'(s4_bo), 32'(vecs[i].exp_bo));
      chk($sformatf("vec%0d latency", i), lat, 5);
      chk($sformatf("vec%0d busy cycles", i), busyc, 4);
      @(negedge clk);
      chk($sformatf("vec%0d done one cycle", i), 32'(s4_done), 0);
      chk($sformatf("vec%0d diff held", i), 32'(s4_diff), 32'(vecs[i].exp_d));
    end

    // start held high: second operation accepted from the DONE cycle
    s4_start = 1'b1; s4_a0 = 4'h9; s4_a1 = 4'h4; s4_bi = 1'b1;
    @(negedge clk);
    s4_a0 = 4'h2; s4_a1 = 4'h7; s4_bi = 1'b0;
    lat = 1;
    while (!s4_done && lat < 30) begin @(negedge clk); lat++; end
    chk("b2b first latency", lat, 5);
    chk("b2b first diff", 32'(s4_diff), 32'h4);
    chk("b2b first bo", 32'(s4_bo), 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("b2b rerun busy", 32'(s4_busy), 1);
        chk("b2b done dropped", 32'(s4_done), 0);
        chk("b2b old diff held in run", 32'(s4_diff), 32'h4);
        s4_start = 1'b0;
      end
    end while (!s4_done && lat < 30);
    chk("b2b done spacing", lat, 5);
    chk("b2b second diff", 32'(s4_diff), 32'hB);
    chk("b2b second bo", 32'(s4_bo), 1);
    @(negedge clk);

    // start during RUN is ignored
    s4_start = 1'b1; s4_a0 = 4'h5; s4_a1 = 4'h3; s4_bi = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) s4_start = 1'b0;
      if (lat == 2) begin
        chk("ignore diff held in run", 32'(s4_diff), 32'hB);
        s4_start = 1'b1; s4_a0 = 4'h0; s4_a1 = 4'hF; s4_bi = 1'b1;
      end
      if (lat == 3) s4_start = 1'b0;
    end while (!s4_done && lat < 30);
    chk("ignore latency", lat, 5);
    chk("ignore diff", 32'(s4_diff), 32'h2);
    chk("ignore bo", 32'(s4_bo), 0);
    @(negedge clk);
    chk("ignore no second run", 32'(s4_busy), 0);

    // reset after two bits of a run that would produce E/1
    s4_start = 1'b1; s4_a0 = 4'h3; s4_a1 = 4'h5; s4_bi = 1'b0;
    @(negedge clk);
    s4_start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(s4_busy), 0);
    chk("abort done", 32'(s4_done), 0);
    chk("abort diff", 32'(s4_diff), 0);
    chk("abort bo", 32'(s4_bo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (s4_done) pulses++;
    end
    chk("abort no done", pulses, 0);
    op4(4'h9, 4'h4, 1'b1, lat, busyc);
    chk("post-reset diff", 32'(s4_diff), 32'h4);
    chk("post-reset bo", 32'(s4_bo), 0);
    chk("post-reset latency", lat, 5);

    for (int i = 0; i < 200; i++) begin
      x1 = 1'($urandom_range(0, 1));
      y1 = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      t = int'(x1) - int'(y1) - int'(b);
      expd = t & 1;
      op1(x1, y1, b, lat);
      chk("n1 diff", 32'(s1_diff), 32'(expd));
      chk("n1 bo", 32'(s1_bo), 32'(t < 0));
      chk("n1 latency", lat, 2);
    end

    for (int i = 0; i < 200; i++) begin
      x8 = 8'($urandom_range(0, 255));
      y8 = 8'($urandom_range(0, 255));
      b  = 1'($urandom_range(0, 1));
      t = int'(x8) - int'(y8) - int'(b);
      expd = t & 8'hFF;
      op8(x8, y8, b, lat);
      chk("n8 diff", 32'(s8_diff), 32'(expd));
      chk("n8 bo", 32'(s8_bo), 32'(t < 0));
      chk("n8 latency", lat, 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
